// File: rtl/load_store_controller.sv
// Load/store sequencer between the execute stage and a word-wide,
// single-port data memory with combinational read. Handles RV32I byte,
// halfword and word accesses; sub-word stores use read-modify-write.
module load_store_controller #(
  parameter int unsigned ADDRESS_WIDTH = 6,
  parameter int unsigned DATA_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_write,
  input  logic [2:0]               req_funct3,
  input  logic [31:0]              req_addr,
  input  logic [DATA_WIDTH-1:0]    req_wdata,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [DATA_WIDTH-1:0]    resp_rdata,
  output logic                     resp_error,
  output logic                     mem_write_en,
  output logic [ADDRESS_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0]    mem_write_data,
  input  logic [DATA_WIDTH-1:0]    mem_read_data
);

  localparam int unsigned BYTE_AW = ADDRESS_WIDTH + 2;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WRITE,
    RESP
  } state_e;

  state_e                  state_q, state_d;
  logic                    write_q, write_d;
  logic [2:0]              funct3_q, funct3_d;
  logic [BYTE_AW-1:0]      addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]   word_q, word_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    error_q, error_d;

  logic                    accept;
  logic                    misaligned;
  logic                    illegal;
  logic                    out_of_range;
  logic [DATA_WIDTH-1:0]   load_ext;
  logic [DATA_WIDTH-1:0]   merged;

  assign req_ready   = (state_q == IDLE);
  assign resp_valid  = (state_q == RESP);
  assign resp_rdata  = rdata_q;
  assign resp_error  = error_q;
  assign mem_address = addr_q[BYTE_AW-1:2];
  assign accept      = req_valid && req_ready;

  // Fault classification of the incoming (not yet registered) request.
  always_comb begin
    misaligned = 1'b0;
    illegal    = 1'b0;
    case (req_funct3)
      F3_B:         ;
      F3_H:         misaligned = req_addr[0];
      F3_W:         misaligned = |req_addr[1:0];
      F3_BU, F3_HU: illegal    = req_write;
      default:      illegal    = 1'b1;
    endcase
    out_of_range = |req_addr[31:BYTE_AW];
  end

  // Lane extraction with sign/zero extension for loads.
  always_comb begin
    logic [7:0]  b;
    logic [15:0] h;
    b = mem_read_data[8*addr_q[1:0] +: 8];
    h = addr_q[1] ? mem_read_data[31:16] : mem_read_data[15:0];
    case (funct3_q)
      F3_B:    load_ext = {{24{b[7]}}, b};
      F3_BU:   load_ext = {24'h0, b};
      F3_H:    load_ext = {{16{h[15]}}, h};
      F3_HU:   load_ext = {16'h0, h};
      default: load_ext = mem_read_data;
    endcase
  end

  // Byte/halfword lane replacement into the captured word for RMW stores.
  always_comb begin
    merged = word_q;
    if (funct3_q == F3_H) begin
      merged[16*addr_q[1] +: 16] = wdata_q[15:0];
    end else begin
      merged[8*addr_q[1:0] +: 8] = wdata_q[7:0];
    end
  end

  // Next-state and memory-side outputs.
  always_comb begin
    state_d        = state_q;
    write_d        = write_q;
    funct3_d       = funct3_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    word_d         = word_q;
    rdata_d        = rdata_q;
    error_d        = error_q;
    mem_write_en   = 1'b0;
    mem_write_data = '0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          write_d  = req_write;
          funct3_d = req_funct3;
          addr_d   = req_addr[BYTE_AW-1:0];
          wdata_d  = req_wdata;
          rdata_d  = '0;
          if (misaligned || illegal || out_of_range) begin
            error_d = 1'b1;
            state_d = RESP;
          end else begin
            error_d = 1'b0;
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        if (!write_q) begin
          rdata_d = load_ext;
          state_d = RESP;
        end else if (funct3_q == F3_W) begin
          mem_write_en   = 1'b1;
          mem_write_data = wdata_q;
          rdata_d        = '0;
          state_d        = RESP;
        end else begin
          word_d  = mem_read_data;
          state_d = WRITE;
        end
      end
      WRITE: begin
        mem_write_en   = 1'b1;
        mem_write_data = merged;
        rdata_d        = '0;
        state_d        = RESP;
      end
      RESP: begin
        if (resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and request registers; async reset kills any in-flight access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      write_q  <= 1'b0;
      funct3_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      word_q   <= '0;
      rdata_q  <= '0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      write_q  <= write_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      word_q   <= word_d;
      rdata_q  <= rdata_d;
      error_q  <= error_d;
    end
  end

endmodule

// File: tb/tb_load_store_controller.sv
// Directed bench for load_store_controller with a behavioural data memory.
module tb_load_store_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic        mem_write_en;
  logic [5:0]  mem_address;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  logic [31:0] mem [64];
  int          wr_cnt = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  load_store_controller #(.ADDRESS_WIDTH(6), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_error(resp_error),
    .mem_write_en(mem_write_en), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;

  assign mem_read_data = mem[mem_address];

  always @(posedge clk) begin
    if (mem_write_en) begin
      mem[mem_address] <= mem_write_data;
      wr_cnt <= wr_cnt + 1;
    end
  end

  // Issue one request from IDLE and wait (bounded) for its response;
  // lat counts edges from the acceptance edge (acceptance edge = 1).
  task automatic run_req(input logic w, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd,
                         output logic [31:0] rd, output logic er,
                         output int lat, output logic ready_hi);
    req_valid  = 1'b1;
    req_write  = w;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat       = 1;
    ready_hi  = req_ready;
    while (!resp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (req_ready) ready_hi = 1'b1;
    end
    rd = resp_rdata;
    er = resp_error;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    n_tests++;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready got %0b want 1", req_ready); end
    n_tests++;
    if ({resp_valid, resp_error, mem_write_en} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags got %b want 000", {resp_valid, resp_error, mem_write_en});
    end
    n_tests++;
    if (resp_rdata !== 32'h0 || mem_write_data !== 32'h0 || mem_address !== 6'h0) begin
      n_fail++; $display("FAIL reset_data got rdata=%h wdata=%h addr=%h want 0", resp_rdata, mem_write_data, mem_address);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_load_byte();
    logic [31:0] rd; logic er, rh; int lat;
    run_req(1'b0, 3'b000, 32'h0D, 32'h0, rd, er, lat, rh);
    n_tests++;
    if (rd !== 32'hFFFFFFAA || er !== 1'b0) begin n_fail++; $display("FAIL lb got %h/%0b want ffffffaa/0", rd, er); end
    n_tests++;
    if (lat !== 2) begin n_fail++; $display("FAIL lb_latency got %0d want 2", lat); end
    run_req(1'b0, 3'b100, 32'h0D, 32'h0, rd, er, lat, rh);
    n_tests++;
    if (rd !== 32'h000000AA) begin n_fail++; $display("FAIL lbu got %h want 000000aa", rd); end
    run_req(1'b0, 3'b101, 32'h0E, 32'h0, rd, er, lat, rh);
    n_tests++;
    if (rd !== 32'h00008899) begin n_fail++; $display("FAIL lhu got %h want 00008899", rd); end
    run_req(1'b0, 3'b001, 32'h0E, 32'h0, rd, er, lat, rh);
    n_tests++;
    if (rd !== 32'hFFFF8899) begin n_fail++; $display("FAIL lh got %h want ffff8899", rd); end
  endtask

  task automatic test_store_byte();
    logic [31:0] rd; logic er, rh; int lat, w0;
    w0 = wr_cnt;
    run_req(1'b1, 3'b000, 32'h0E, 32'h12345611, rd, er, lat, rh);
    n_tests++;
    if (mem[3] !== 32'h8811AABB) begin n_fail++; $display("FAIL sb_merge got %h want 8811aabb", mem[3]); end
    n_tests++;
    if (wr_cnt - w0 !== 1) begin n_fail++; $display("FAIL sb_we_cycles got %0d want 1", wr_cnt - w0); end
    n_tests++;
    if (lat !== 3 || rd !== 32'h0 || er !== 1'b0) begin
      n_fail++; $display("FAIL sb_resp got lat=%0d rd=%h er=%0b want 3/0/0", lat, rd, er);
    end
    run_req(1'b1, 3'b001, 32'h0A, 32'hFFFFCAFE, rd, er, lat, rh);
    n_tests++;
    if (mem[2] !== 32'hCAFE0000) begin n_fail++; $display("FAIL sh_merge got %h want cafe0000", mem[2]); end
  endtask

  task automatic test_word();
    logic [31:0] rd; logic er, rh; int lat, w0;
    w0 = wr_cnt;
    run_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, rd, er, lat, rh);
    n_tests++;
    if (lat !== 2 || rd !== 32'h0 || rh !== 1'b0) begin
      n_fail++; $display("FAIL sw_resp got lat=%0d rd=%h rdy=%0b want 2/0/0", lat, rd, rh);
    end
    n_tests++;
    if (mem[4] !== 32'hDEADBEEF || wr_cnt - w0 !== 1) begin
      n_fail++; $display("FAIL sw_mem got %h wr=%0d want deadbeef/1", mem[4], wr_cnt - w0);
    end
    run_req(1'b0, 3'b010, 32'h10, 32'h0, rd, er, lat, rh);
    n_tests++;
    if (rd !== 32'hDEADBEEF || lat !== 2 || rh !== 1'b0) begin
      n_fail++; $display("FAIL lw got %h lat=%0d rdy=%0b want deadbeef/2/0", rd, lat, rh);
    end
    n_tests++;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL lw_ready_after got %0b want 1", req_ready); end
  endtask

  task automatic test_faults();
    logic [31:0] rd; logic er, rh; int lat, w0;
    logic [31:0] m3;
    w0 = wr_cnt;
    m3 = mem[3];
    run_req(1'b0, 3'b001, 32'h0D, 32'h0, rd, er, lat, rh);
    n_tests++;
    if (er !== 1'b1 || rd !== 32'h0 || lat !== 1) begin
      n_fail++; $display("FAIL fault_lh_misaligned got er=%0b rd=%h lat=%0d want 1/0/1", er, rd, lat);
    end
    run_req(1'b1, 3'b010, 32'h102, 32'h55555555, rd, er, lat, rh);
    n_tests++;
    if (er !== 1'b1 || rd !== 32'h0 || lat !== 1) begin
      n_fail++; $display("FAIL fault_sw_range got er=%0b rd=%h lat=%0d want 1/0/1", er, rd, lat);
    end
    run_req(1'b1, 3'b010, 32'h100, 32'h55555555, rd, er, lat, rh);
    n_tests++;
    if (er !== 1'b1 || lat !== 1) begin
      n_fail++; $display("FAIL fault_sw_range_aligned got er=%0b lat=%0d want 1/1", er, lat);
    end
    run_req(1'b0, 3'b011, 32'h0, 32'h0, rd, er, lat, rh);
    n_tests++;
    if (er !== 1'b1 || rd !== 32'h0 || lat !== 1) begin
      n_fail++; $display("FAIL fault_funct3 got er=%0b rd=%h lat=%0d want 1/0/1", er, rd, lat);
    end
    run_req(1'b1, 3'b100, 32'h0C, 32'h0, rd, er, lat, rh);
    n_tests++;
    if (er !== 1'b1) begin n_fail++; $display("FAIL fault_store_f3 got er=%0b want 1", er); end
    n_tests++;
    if (wr_cnt !== w0 || mem[3] !== m3 || mem[0] !== 32'h0) begin
      n_fail++; $display("FAIL fault_no_write got wr=%0d m3=%h want %0d/%h", wr_cnt - w0, mem[3], 0, m3);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] held; int w0;
    logic bad_hold;
    w0 = wr_cnt;
    resp_ready = 1'b0;
    req_valid  = 1'b1; req_write = 1'b0; req_funct3 = 3'b010;
    req_addr   = 32'h10; req_wdata = 32'h0;
    @(posedge clk); #1;
    // Keep a different request pending; it must not be taken.
    req_addr = 32'h0C;
    @(posedge clk); #1;
    n_tests++;
    if (resp_valid !== 1'b1 || resp_rdata !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL bp_first got v=%0b rd=%h want 1/deadbeef", resp_valid, resp_rdata);
    end
    held = resp_rdata;
    bad_hold = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (resp_valid !== 1'b1 || resp_rdata !== held || req_ready !== 1'b0 || resp_error !== 1'b0)
        bad_hold = 1'b1;
    end
    n_tests++;
    if (bad_hold !== 1'b0 || wr_cnt !== w0) begin
      n_fail++; $display("FAIL bp_hold got bad=%0b wr=%0d want 0/0", bad_hold, wr_cnt - w0);
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      n_fail++; $display("FAIL bp_release got rdy=%0b v=%0b want 1/0", req_ready, resp_valid);
    end
  endtask

  task automatic test_reset_mid_rmw();
    logic [31:0] rd; logic er, rh; int lat, w0;
    w0 = wr_cnt;
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b001;
    req_addr  = 32'h04; req_wdata = 32'hAAAA5555;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    n_tests++;
    if (mem_write_en !== 1'b1 || mem_address !== 6'd1) begin
      n_fail++; $display("FAIL rmw_write_phase got we=%0b addr=%0d want 1/1", mem_write_en, mem_address);
    end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (mem_write_en !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 1'b1 ||
        mem_address !== 6'd0 || mem_write_data !== 32'h0 || resp_rdata !== 32'h0 || resp_error !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_outputs got we=%0b v=%0b rdy=%0b addr=%0d want 0/0/1/0",
                         mem_write_en, resp_valid, req_ready, mem_address);
    end
    @(posedge clk); #1;
    n_tests++;
    if (mem[1] !== 32'h11223344 || wr_cnt !== w0) begin
      n_fail++; $display("FAIL rst_mid_mem got %h wr=%0d want 11223344/0", mem[1], wr_cnt - w0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_release got rdy=%0b v=%0b want 1/0", req_ready, resp_valid);
    end
    run_req(1'b0, 3'b010, 32'h04, 32'h0, rd, er, lat, rh);
    n_tests++;
    if (rd !== 32'h11223344 || er !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_reload got %h/%0b want 11223344/0", rd, er);
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[1] = 32'h11223344;
    mem[3] = 32'h8899AABB;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    resp_ready = 1'b1;
    test_reset();
    test_load_byte();
    test_store_byte();
    test_word();
    test_faults();
    test_backpressure();
    test_reset_mid_rmw();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
